// File: rtl/conv_pkg.sv
// Shared types and constants for the conv scheduler slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package conv_pkg;

    localparam int CONV_CNT_W  = 16;
    localparam int CONV_AH_DEF = 4;
    localparam int CONV_AW_DEF = 4;

    // Cycles needed to push the last operands through the array skew.
    localparam int FLUSH_CYCLES = CONV_AH_DEF + CONV_AW_DEF - 1;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_BANKS = 3'd1,
        LOAD_W     = 3'd2,
        STREAM     = 3'd3,
        FLUSH      = 3'd4,
        DRAIN      = 3'd5,
        RELEASE    = 3'd6
    } conv_sched_state_e;

    typedef struct packed {
        logic [CONV_CNT_W-1:0] fx;
        logic [CONV_CNT_W-1:0] fy;
        logic [CONV_CNT_W-1:0] ic1;
        logic [CONV_CNT_W-1:0] oc1;
        logic [CONV_CNT_W-1:0] ox0;
        logic [CONV_CNT_W-1:0] oy0;
    } conv_cfg_t;

    // Flush length for an arbitrary array shape.
    function automatic int conv_flush_cycles(input int ah, input int aw);
        return ah + aw - 1;
    endfunction

endpackage

// File: rtl/conv_loop_nest.sv
// fx/fy/ic1/oc1 loop counter: fx fastest, then fy, then ic1; oc1 steps per output tile.
// Latency: indices and flags update one cycle after an advance strobe.
// Backpressure: none; advances only when strobed by the scheduler.
module conv_loop_nest
    import conv_pkg::*;
#(
    parameter int COUNTER_WIDTH = CONV_CNT_W
)
(
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_clear,
    input  logic                     i_advance_inner,
    input  logic                     i_advance_outer,
    input  logic [COUNTER_WIDTH-1:0] i_bnd_fx,
    input  logic [COUNTER_WIDTH-1:0] i_bnd_fy,
    input  logic [COUNTER_WIDTH-1:0] i_bnd_ic1,
    input  logic [COUNTER_WIDTH-1:0] i_bnd_oc1,
    output logic                     o_inner_last,
    output logic                     o_outer_last,
    output logic                     o_first_acc
);

    localparam logic [COUNTER_WIDTH-1:0] ONE = COUNTER_WIDTH'(1);

    logic [COUNTER_WIDTH-1:0] r_fx;
    logic [COUNTER_WIDTH-1:0] r_fy;
    logic [COUNTER_WIDTH-1:0] r_ic1;
    logic [COUNTER_WIDTH-1:0] r_oc1;

    logic w_fx_last;
    logic w_fy_last;
    logic w_ic1_last;
    logic w_oc1_last;

    // Last-index detection against bound minus one (bounds are never 0 while active).
    always_comb begin
        w_fx_last    = (r_fx  == i_bnd_fx  - ONE);
        w_fy_last    = (r_fy  == i_bnd_fy  - ONE);
        w_ic1_last   = (r_ic1 == i_bnd_ic1 - ONE);
        w_oc1_last   = (r_oc1 == i_bnd_oc1 - ONE);
        o_inner_last = w_fx_last && w_fy_last && w_ic1_last;
        o_outer_last = w_oc1_last;
        o_first_acc  = (r_fx == '0) && (r_fy == '0) && (r_ic1 == '0);
    end

    // Ripple-carry style index update; outer advance also resets the inner nest.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fx  <= '0;
            r_fy  <= '0;
            r_ic1 <= '0;
            r_oc1 <= '0;
        end else if (i_clear) begin
            r_fx  <= '0;
            r_fy  <= '0;
            r_ic1 <= '0;
            r_oc1 <= '0;
        end else if (i_advance_outer) begin
            r_fx  <= '0;
            r_fy  <= '0;
            r_ic1 <= '0;
            r_oc1 <= w_oc1_last ? '0 : r_oc1 + ONE;
        end else if (i_advance_inner) begin
            if (w_fx_last) begin
                r_fx <= '0;
                if (w_fy_last) begin
                    r_fy  <= '0;
                    r_ic1 <= w_ic1_last ? '0 : r_ic1 + ONE;
                end else begin
                    r_fy <= r_fy + ONE;
                end
            end else begin
                r_fx <= r_fx + ONE;
            end
        end
    end

endmodule

// File: rtl/conv_scheduler.sv
// Sequencer for buffers and systolic array: config, bank wait, weight load, stream, flush, drain, release.
// Latency: all outputs registered; strobes track the state one cycle after the deciding edge.
// Backpressure: drain holds ofmap_drain_vld and the beat count while ofmap_drain_rdy is low.
module conv_scheduler
    import conv_pkg::*;
#(
    parameter int ARRAY_HEIGHT  = CONV_AH_DEF,
    parameter int ARRAY_WIDTH   = CONV_AW_DEF,
    parameter int COUNTER_WIDTH = CONV_CNT_W
)
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_vld,
    output logic                     cfg_rdy,
    input  logic [COUNTER_WIDTH-1:0] cfg_fx,
    input  logic [COUNTER_WIDTH-1:0] cfg_fy,
    input  logic [COUNTER_WIDTH-1:0] cfg_ic1,
    input  logic [COUNTER_WIDTH-1:0] cfg_oc1,
    input  logic [COUNTER_WIDTH-1:0] cfg_ox0,
    input  logic [COUNTER_WIDTH-1:0] cfg_oy0,
    input  logic                     ifmap_bank_ready,
    input  logic                     weight_bank_ready,
    output logic                     ifmap_bank_release,
    output logic                     weight_bank_release,
    output logic                     weight_ren,
    output logic                     input_ren,
    output logic                     weight_write_enable,
    output logic                     sys_arr_enable,
    output logic                     acc_first,
    output logic                     ofmap_drain_vld,
    input  logic                     ofmap_drain_rdy,
    output logic                     busy,
    output logic                     done
);

    localparam int CNT_W = 2 * COUNTER_WIDTH;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(ARRAY_HEIGHT - 1);
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(conv_flush_cycles(ARRAY_HEIGHT, ARRAY_WIDTH) - 1);

    conv_sched_state_e r_state;
    conv_sched_state_e w_next_state;
    conv_cfg_t         r_cfg;
    logic [CNT_W-1:0]  r_npix_m1;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;

    logic r_cfg_rdy, r_busy, r_weight_ren, r_wwe, r_input_ren, r_sys_en;
    logic r_acc_first, r_drain_vld, r_release, r_done;

    logic w_cfg_hs, w_cfg_zero, w_done_zero;
    logic w_adv_inner, w_adv_outer;
    logic w_inner_last, w_outer_last, w_first_acc;

    assign w_cfg_zero = (cfg_fx == '0) || (cfg_fy == '0) || (cfg_ic1 == '0) ||
                        (cfg_oc1 == '0) || (cfg_ox0 == '0) || (cfg_oy0 == '0);

    conv_loop_nest #(.COUNTER_WIDTH(COUNTER_WIDTH)) u_loop_nest (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_clear         (w_cfg_hs),
        .i_advance_inner (w_adv_inner),
        .i_advance_outer (w_adv_outer),
        .i_bnd_fx        (r_cfg.fx),
        .i_bnd_fy        (r_cfg.fy),
        .i_bnd_ic1       (r_cfg.ic1),
        .i_bnd_oc1       (r_cfg.oc1),
        .o_inner_last    (w_inner_last),
        .o_outer_last    (w_outer_last),
        .o_first_acc     (w_first_acc)
    );

    // Next-state, phase counter and loop-nest strobes.
    always_comb begin
        w_next_state = r_state;
        w_cnt_nxt    = r_cnt;
        w_cfg_hs     = 1'b0;
        w_done_zero  = 1'b0;
        w_adv_inner  = 1'b0;
        w_adv_outer  = 1'b0;
        case (r_state)
            IDLE: begin
                if (cfg_vld && r_cfg_rdy) begin
                    w_cfg_hs  = 1'b1;
                    w_cnt_nxt = '0;
                    if (w_cfg_zero) w_done_zero  = 1'b1;
                    else            w_next_state = WAIT_BANKS;
                end
            end
            WAIT_BANKS: begin
                if (ifmap_bank_ready && weight_bank_ready) w_next_state = LOAD_W;
            end
            LOAD_W: begin
                if (r_cnt == LOAD_LAST) begin
                    w_cnt_nxt    = '0;
                    w_next_state = STREAM;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            STREAM: begin
                if (r_cnt == r_npix_m1) begin
                    w_cnt_nxt    = '0;
                    w_adv_inner  = 1'b1;
                    w_next_state = w_inner_last ? FLUSH : LOAD_W;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            FLUSH: begin
                if (r_cnt == FLUSH_LAST) begin
                    w_cnt_nxt    = '0;
                    w_next_state = DRAIN;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            DRAIN: begin
                if (ofmap_drain_rdy) begin
                    if (r_cnt == r_npix_m1) begin
                        w_cnt_nxt    = '0;
                        w_adv_outer  = 1'b1;
                        w_next_state = w_outer_last ? RELEASE : LOAD_W;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                    end
                end
            end
            RELEASE: w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // State, counter, latched config, and registered output strobes decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_cfg        <= '0;
            r_npix_m1    <= '0;
            r_cfg_rdy    <= 1'b0;
            r_busy       <= 1'b0;
            r_weight_ren <= 1'b0;
            r_wwe        <= 1'b0;
            r_input_ren  <= 1'b0;
            r_sys_en     <= 1'b0;
            r_acc_first  <= 1'b0;
            r_drain_vld  <= 1'b0;
            r_release    <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_nxt;
            if (w_cfg_hs) begin
                r_cfg <= '{fx: cfg_fx, fy: cfg_fy, ic1: cfg_ic1,
                           oc1: cfg_oc1, ox0: cfg_ox0, oy0: cfg_oy0};
            end
            // Pixel count settles while waiting for banks, keeping the multiplier off the config path.
            if (r_state == WAIT_BANKS) begin
                r_npix_m1 <= CNT_W'(r_cfg.ox0) * CNT_W'(r_cfg.oy0) - CNT_ONE;
            end
            r_cfg_rdy    <= (w_next_state == IDLE);
            r_busy       <= (w_next_state != IDLE);
            r_weight_ren <= (w_next_state == LOAD_W);
            r_wwe        <= r_weight_ren;
            r_input_ren  <= (w_next_state == STREAM);
            r_sys_en     <= r_input_ren || (w_next_state == FLUSH);
            r_acc_first  <= r_input_ren && w_first_acc;
            r_drain_vld  <= (w_next_state == DRAIN);
            r_release    <= (w_next_state == RELEASE);
            r_done       <= (w_next_state == RELEASE) || w_done_zero;
        end
    end

    assign cfg_rdy             = r_cfg_rdy;
    assign busy                = r_busy;
    assign weight_ren          = r_weight_ren;
    assign weight_write_enable = r_wwe;
    assign input_ren           = r_input_ren;
    assign sys_arr_enable      = r_sys_en;
    assign acc_first           = r_acc_first;
    assign ofmap_drain_vld     = r_drain_vld;
    assign ifmap_bank_release  = r_release;
    assign weight_bank_release = r_release;
    assign done                = r_done;

endmodule

// File: tb/tb_conv_scheduler.sv
// Directed bench for conv_scheduler with a queue of expected results.
// Latency: n/a.
// Backpressure: drain ready optionally toggled every cycle.
module tb_conv_scheduler;

    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_vld = 1'b0;
    logic          cfg_rdy;
    logic [CW-1:0] cfg_fx = '0, cfg_fy = '0, cfg_ic1 = '0, cfg_oc1 = '0, cfg_ox0 = '0, cfg_oy0 = '0;
    logic          ifmap_bank_ready = 1'b0;
    logic          weight_bank_ready = 1'b0;
    logic          ifmap_bank_release, weight_bank_release;
    logic          weight_ren, input_ren, weight_write_enable, sys_arr_enable, acc_first;
    logic          ofmap_drain_vld;
    logic          ofmap_drain_rdy = 1'b1;
    logic          busy, done;

    conv_scheduler #(.ARRAY_HEIGHT(4), .ARRAY_WIDTH(4), .COUNTER_WIDTH(CW)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .cfg_vld             (cfg_vld),
        .cfg_rdy             (cfg_rdy),
        .cfg_fx              (cfg_fx),
        .cfg_fy              (cfg_fy),
        .cfg_ic1             (cfg_ic1),
        .cfg_oc1             (cfg_oc1),
        .cfg_ox0             (cfg_ox0),
        .cfg_oy0             (cfg_oy0),
        .ifmap_bank_ready    (ifmap_bank_ready),
        .weight_bank_ready   (weight_bank_ready),
        .ifmap_bank_release  (ifmap_bank_release),
        .weight_bank_release (weight_bank_release),
        .weight_ren          (weight_ren),
        .input_ren           (input_ren),
        .weight_write_enable (weight_write_enable),
        .sys_arr_enable      (sys_arr_enable),
        .acc_first           (acc_first),
        .ofmap_drain_vld     (ofmap_drain_vld),
        .ofmap_drain_rdy     (ofmap_drain_rdy),
        .busy                (busy),
        .done                (done)
    );

    always #5 clk = ~clk;

    // {cfg_rdy, busy, weight_ren, wwe, input_ren, sys_en, acc_first, drain_vld, if_rel, w_rel, done}
    logic [10:0] w_out;
    assign w_out = {cfg_rdy, busy, weight_ren, weight_write_enable, input_ren, sys_arr_enable,
                    acc_first, ofmap_drain_vld, ifmap_bank_release, weight_bank_release, done};

    int unsigned n_chk = 0;
    int unsigned n_pass = 0;
    int unsigned exp_q[$];
    logic [10:0] tr_q[$];

    // Running activity totals sampled mid-cycle.
    int unsigned m_wren = 0, m_iren = 0, m_beats = 0, m_acc = 0, m_done = 0;
    int unsigned m_rel = 0, m_act = 0, m_busy = 0, m_viol = 0;
    logic p_vld = 1'b0, p_rdy = 1'b0;

    always @(negedge clk) begin
        m_wren  <= m_wren + 32'(weight_ren);
        m_iren  <= m_iren + 32'(input_ren);
        m_beats <= m_beats + 32'(ofmap_drain_vld && ofmap_drain_rdy);
        m_acc   <= m_acc + 32'(acc_first && sys_arr_enable);
        m_done  <= m_done + 32'(done);
        m_rel   <= m_rel + 32'(ifmap_bank_release || weight_bank_release);
        m_act   <= m_act + 32'(weight_ren || input_ren || weight_write_enable || sys_arr_enable ||
                               ofmap_drain_vld || ifmap_bank_release || weight_bank_release);
        m_busy  <= m_busy + 32'(busy);
        m_viol  <= m_viol + 32'(p_vld && !p_rdy && !ofmap_drain_vld);
        p_vld   <= ofmap_drain_vld;
        p_rdy   <= ofmap_drain_rdy;
    end

    task automatic chk(input string tag, input longint unsigned obs, input longint unsigned exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rdy();
        for (int i = 0; i < 50 && !cfg_rdy; i++) step();
        chk("cfg_rdy_wait", cfg_rdy, 1);
    endtask

    task automatic drive_cfg(input int fx, input int fy, input int ic, input int oc, input int ox, input int oy);
        cfg_fx  = CW'(fx);  cfg_fy  = CW'(fy);  cfg_ic1 = CW'(ic);
        cfg_oc1 = CW'(oc);  cfg_ox0 = CW'(ox);  cfg_oy0 = CW'(oy);
        cfg_vld = 1'b1;
    endtask

    task automatic send_cfg(input int fx, input int fy, input int ic, input int oc, input int ox, input int oy);
        drive_cfg(fx, fy, ic, oc, ox, oy);
        step();
        cfg_vld = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, input bit toggle);
        int unsigned base;
        base = m_done;
        for (int i = 0; i < max_cyc; i++) begin
            step();
            if (toggle) ofmap_drain_rdy = ~ofmap_drain_rdy;
            if (m_done != base) break;
        end
        chk("done_seen", (m_done != base), 1);
        ofmap_drain_rdy = 1'b1;
    endtask

    int unsigned b_wren, b_iren, b_beats, b_acc, b_done, b_rel, b_act, b_busy, b_viol;

    task automatic snap();
        b_wren = m_wren; b_iren = m_iren; b_beats = m_beats; b_acc = m_acc; b_done = m_done;
        b_rel = m_rel; b_act = m_act; b_busy = m_busy; b_viol = m_viol;
    endtask

    initial begin
        // Reset state.
        repeat (3) step();
        chk("reset_outputs", w_out, 0);
        rst_n = 1'b1;
        chk("cfg_rdy_before_edge", cfg_rdy, 0);
        step();
        chk("cfg_rdy_after_edge", cfg_rdy, 1);

        // Test 1: all bounds 1, cycle-exact trace.
        for (int k = 0; k < 18; k++) begin
            tr_q.push_back({1'(k == 0 || k >= 16), 1'(k >= 1 && k <= 15), 1'(k >= 2 && k <= 5),
                            1'(k >= 3 && k <= 6), 1'(k == 6), 1'(k >= 7 && k <= 13), 1'(k == 7),
                            1'(k == 14), 1'(k == 15), 1'(k == 15), 1'(k == 15)});
        end
        wait_rdy();
        ifmap_bank_ready  = 1'b1;
        weight_bank_ready = 1'b1;
        drive_cfg(1, 1, 1, 1, 1, 1);
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            chk($sformatf("trace_c%0d", k), w_out, tr_q.pop_front());
            step();
            if (k == 0) cfg_vld = 1'b0;
        end

        // Test 2: full nest, drain always ready.
        snap();
        exp_q.push_back(288); exp_q.push_back(648); exp_q.push_back(36);
        exp_q.push_back(36);  exp_q.push_back(1);   exp_q.push_back(1);
        wait_rdy();
        send_cfg(3, 3, 2, 4, 3, 3);
        wait_done(5000, 1'b0);
        repeat (3) step();
        chk("t2_weight_ren", m_wren - b_wren, exp_q.pop_front());
        chk("t2_input_ren", m_iren - b_iren, exp_q.pop_front());
        chk("t2_drain_beats", m_beats - b_beats, exp_q.pop_front());
        chk("t2_acc_first", m_acc - b_acc, exp_q.pop_front());
        chk("t2_done", m_done - b_done, exp_q.pop_front());
        chk("t2_release", m_rel - b_rel, exp_q.pop_front());

        // Test 3: same config, drain ready toggling.
        snap();
        exp_q.push_back(36); exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(288);
        wait_rdy();
        send_cfg(3, 3, 2, 4, 3, 3);
        wait_done(8000, 1'b1);
        repeat (3) step();
        chk("t3_drain_beats", m_beats - b_beats, exp_q.pop_front());
        chk("t3_vld_drop", m_viol - b_viol, exp_q.pop_front());
        chk("t3_done", m_done - b_done, exp_q.pop_front());
        chk("t3_weight_ren", m_wren - b_wren, exp_q.pop_front());

        // Test 4: zero bound completes immediately.
        wait_rdy();
        snap();
        exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(1);
        send_cfg(2, 2, 0, 2, 2, 2);
        chk("t4_done_pulse", done, 1);
        chk("t4_busy", busy, 0);
        chk("t4_cfg_rdy", cfg_rdy, 1);
        step();
        chk("t4_done_drop", done, 0);
        repeat (10) step();
        chk("t4_activity", m_act - b_act, exp_q.pop_front());
        chk("t4_busy_cycles", m_busy - b_busy, exp_q.pop_front());
        chk("t4_done_count", m_done - b_done, exp_q.pop_front());

        // Test 5: staggered bank readiness.
        ifmap_bank_ready  = 1'b0;
        weight_bank_ready = 1'b0;
        wait_rdy();
        snap();
        send_cfg(1, 1, 1, 1, 1, 1);
        repeat (5) step();
        ifmap_bank_ready = 1'b1;
        repeat (20) step();
        weight_bank_ready = 1'b1;
        @(negedge clk);
        chk("t5_no_load_yet", weight_ren, 0);
        chk("t5_wren_while_waiting", m_wren - b_wren, 0);
        step();
        chk("t5_load_starts", weight_ren, 1);
        wait_done(200, 1'b0);

        // Test 6: reset in the middle of STREAM.
        wait_rdy();
        send_cfg(3, 3, 2, 4, 3, 3);
        for (int i = 0; i < 200 && !input_ren; i++) step();
        chk("t6_in_stream", input_ren, 1);
        snap();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_outputs_cleared", w_out, 0);
        repeat (3) step();
        rst_n = 1'b1;
        repeat (3) step();
        chk("t6_no_done", m_done - b_done, 0);
        chk("t6_no_release", m_rel - b_rel, 0);
        wait_rdy();
        snap();
        send_cfg(1, 1, 1, 1, 1, 1);
        wait_done(200, 1'b0);
        repeat (2) step();
        chk("t6_done_after_reset", m_done - b_done, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
